// File: rtl/temp_alert_controller.sv
// Over-temperature alert controller: threshold window with hysteresis, a
// consecutive-sample fault queue, a peak-temperature register and a threshold sanity flag.
module temp_alert_controller #(
    parameter int unsigned       FAULT_QUEUE = 4,      // legal 1..15
    parameter logic signed [7:0] PEAK_INIT   = 8'sh80  // -128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              temp_valid,
    input  logic signed [7:0] temperature,
    input  logic signed [7:0] t_high,
    input  logic signed [7:0] t_low,
    input  logic              peak_clr,
    output logic              alert,
    output logic [1:0]        state,
    output logic [3:0]        fault_cnt,
    output logic signed [7:0] peak_temp,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_PEND_HIGH  = 2'd1,
        ST_ALERT      = 2'd2,
        ST_PEND_CLEAR = 2'd3
    } state_t;

    localparam logic [3:0] FQ_LIMIT   = 4'(FAULT_QUEUE);
    localparam bit         SINGLE_HIT = (FAULT_QUEUE == 1);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next, cnt_inc;
    logic              alert_reg, alert_next;
    logic              cfg_err_reg, cfg_err_next;
    logic signed [7:0] peak_reg, peak_next;
    logic              hi, lo, advance;

    // All operands are declared signed, so these are two's-complement compares.
    assign hi           = (temperature >= t_high);
    assign lo           = (temperature <= t_low);
    assign cfg_err_next = (t_low > t_high);

    // A misconfigured window freezes the qualifier; the registered flag gates it.
    assign advance = temp_valid && !cfg_err_reg;
    assign cnt_inc = cnt_reg + 4'd1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (advance) begin
            case (state_reg)
                ST_NORMAL: begin
                    if (hi) begin
                        if (SINGLE_HIT) begin
                            state_next = ST_ALERT;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_PEND_HIGH;
                            cnt_next   = 4'd1;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end
                ST_PEND_HIGH: begin
                    if (hi) begin
                        if (cnt_inc == FQ_LIMIT) begin
                            state_next = ST_ALERT;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = ST_NORMAL;
                        cnt_next   = 4'd0;
                    end
                end
                ST_ALERT: begin
                    if (lo) begin
                        if (SINGLE_HIT) begin
                            state_next = ST_NORMAL;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_PEND_CLEAR;
                            cnt_next   = 4'd1;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end
                ST_PEND_CLEAR: begin
                    if (lo) begin
                        if (cnt_inc == FQ_LIMIT) begin
                            state_next = ST_NORMAL;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = ST_ALERT;
                        cnt_next   = 4'd0;
                    end
                end
                default: begin
                    state_next = ST_NORMAL;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    assign alert_next = (state_next == ST_ALERT) || (state_next == ST_PEND_CLEAR);

    // A clear coincident with a sample restarts tracking from that sample.
    always_comb begin
        peak_next = peak_reg;
        if (peak_clr) begin
            peak_next = temp_valid ? temperature : PEAK_INIT;
        end else if (temp_valid && (temperature > peak_reg)) begin
            peak_next = temperature;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_NORMAL;
            cnt_reg     <= 4'd0;
            alert_reg   <= 1'b0;
            cfg_err_reg <= 1'b0;
            peak_reg    <= PEAK_INIT;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            alert_reg   <= alert_next;
            cfg_err_reg <= cfg_err_next;
            peak_reg    <= peak_next;
        end
    end

    assign alert     = alert_reg;
    assign state     = state_reg;
    assign fault_cnt = cnt_reg;
    assign peak_temp = peak_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_temp_alert_controller.sv
// Directed bench for temp_alert_controller: fault queue of 4 on the main
// instance, plus a single-sample instance for the FAULT_QUEUE=1 corner.
module tb_temp_alert_controller;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              temp_valid = 1'b0;
    logic signed [7:0] temperature = 8'sd0;
    logic signed [7:0] t_high = 8'sd50;
    logic signed [7:0] t_low = 8'sd45;
    logic              peak_clr = 1'b0;

    logic              alert0, alert1;
    logic [1:0]        state0, state1;
    logic [3:0]        cnt0, cnt1;
    logic signed [7:0] peak0, peak1;
    logic              cfg0, cfg1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    temp_alert_controller #(.FAULT_QUEUE(4)) dut (
        .clk(clk), .rst(rst), .temp_valid(temp_valid), .temperature(temperature),
        .t_high(t_high), .t_low(t_low), .peak_clr(peak_clr),
        .alert(alert0), .state(state0), .fault_cnt(cnt0), .peak_temp(peak0), .cfg_err(cfg0)
    );

    temp_alert_controller #(.FAULT_QUEUE(1)) dut_q1 (
        .clk(clk), .rst(rst), .temp_valid(temp_valid), .temperature(temperature),
        .t_high(t_high), .t_low(t_low), .peak_clr(peak_clr),
        .alert(alert1), .state(state1), .fault_cnt(cnt1), .peak_temp(peak1), .cfg_err(cfg1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, then sample just after the capturing edge.
    task automatic apply(input logic v, input logic signed [7:0] t, input logic c);
        temp_valid  = v;
        temperature = t;
        peak_clr    = c;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
        peak_clr   = 1'b0;
        $display("cycle: valid=%0b temp=%0d clr=%0b -> state=%0d cnt=%0d alert=%0b peak=%0d cfg_err=%0b",
                 v, t, c, state0, cnt0, alert0, peak0, cfg0);
    endtask

    task automatic chk_main(input string tag, input int st, input int cnt, input int al);
        chk({tag, ".state"}, state0, st);
        chk({tag, ".cnt"}, cnt0, cnt);
        chk({tag, ".alert"}, alert0, al);
    endtask

    task automatic chk_reset0(input string tag);
        chk_main(tag, 0, 0, 0);
        chk({tag, ".peak"}, peak0, -128);
        chk({tag, ".cfg"}, cfg0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset0("reset");
        @(negedge clk);
        rst = 1'b0;

        // Entry into ALERT after four consecutive hot samples
        apply(1, 51, 0); chk_main("hi1", 1, 1, 0);
        apply(1, 52, 0); chk_main("hi2", 1, 2, 0);
        apply(1, 53, 0); chk_main("hi3", 1, 3, 0);
        apply(1, 54, 0); chk_main("hi4", 2, 0, 1);
        apply(0, 99, 0); chk_main("idle", 2, 0, 1);

        // Hysteresis band and clear queue
        apply(1, 47, 0); chk_main("band", 2, 0, 1);
        apply(1, 45, 0); chk_main("lo1", 3, 1, 1);
        apply(1, 44, 0); chk_main("lo2", 3, 2, 1);
        apply(1, 40, 0); chk_main("lo3", 3, 3, 1);
        apply(1, -3, 0); chk_main("lo4", 0, 0, 0);

        // Broken run of hot samples restarts the count
        apply(1, 55, 0); chk_main("brk1", 1, 1, 0);
        apply(1, 55, 0); chk_main("brk2", 1, 2, 0);
        apply(1, 49, 0); chk_main("brk3", 0, 0, 0);
        apply(1, 55, 0); chk_main("brk4", 1, 1, 0);
        apply(1, 10, 0); chk_main("brk5", 0, 0, 0);
        chk("peak_pre", peak0, 55);

        // Peak register
        apply(0, 0, 1);   chk("peak_clr0", peak0, -128);
        apply(1, -20, 0); chk("peak_a", peak0, -20);
        apply(1, 30, 0);  chk("peak_b", peak0, 30);
        apply(1, 12, 0);  chk("peak_c", peak0, 30);
        apply(1, 5, 1);   chk("peak_clr_smp", peak0, 5);
        apply(1, -1, 0);  chk("peak_d", peak0, 5);
        apply(0, 0, 1);   chk("peak_clr1", peak0, -128);

        // Inverted window freezes the qualifier but not peak tracking
        t_low = 8'sd60;
        apply(0, 0, 0);   chk("cfg_set", cfg0, 1);
        apply(1, 100, 0); chk_main("cfg_hold1", 0, 0, 0);
        apply(1, 100, 0); chk_main("cfg_hold2", 0, 0, 0);
        chk("cfg_peak", peak0, 100);
        t_low = 8'sd45;
        apply(0, 0, 0);   chk("cfg_clr", cfg0, 0);
        apply(1, 100, 0); chk_main("resume1", 1, 1, 0);
        apply(1, 100, 0); chk_main("resume2", 1, 2, 0);

        // Async reset mid-pending, observed before the next edge
        rst = 1'b1;
        #1;
        chk_reset0("rst_pend");
        @(negedge clk);
        rst = 1'b0;

        // Single-sample queue instance
        apply(1, 50, 0);
        chk("q1_enter.state", state1, 2);
        chk("q1_enter.alert", alert1, 1);
        chk("q1_enter.cnt", cnt1, 0);
        chk("q4_same.state", state0, 1);
        apply(1, 45, 0);
        chk("q1_leave.state", state1, 0);
        chk("q1_leave.alert", alert1, 0);
        apply(1, 50, 0);
        chk("q1_again.state", state1, 2);
        rst = 1'b1;
        #1;
        chk("q1_rst.state", state1, 0);
        chk("q1_rst.alert", alert1, 0);
        chk("q1_rst.cnt", cnt1, 0);
        chk("q1_rst.peak", peak1, -128);
        chk("q1_rst.cfg", cfg1, 0);
        chk_reset0("q4_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
